alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Sequencer and two-port arbiter for the shared 64-bit combinational ALU in the MIPS64 execute stage. It accepts operations from two requesters (port 0: integer pipeline, port 1: branch/compare unit) over valid/ready handshakes and grants one at a time. It drives the ALU from registered operands and holds a MULT for a configurable number of cycles so the multiplier path can be multicycle-constrained. Results go out on a single tagged response channel with backpressure.

## Interface
- SIZE, 64, operand/result width
- MULT_CYCLES, 4, cycles the ALU is held for MULT (control 4'b0110); legal range 1..15
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous and active-low
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_control / req1_control  in  4  ALU op: 1 AND, 2 OR, 3 ADD, 4 SUB, 5 EQ, 6 MULT, 7 NOR
- req0_a, req0_b / req1_a, req1_b  in  SIZE  operands
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  1  requester that owns the result
- resp_out  out  SIZE  result
- resp_zero  out  1  result == 0
- resp_overflow  out  1  carry/borrow out; ADD/SUB only
- alu_control  out  4  to shared ALU
- alu_a, alu_b  out  SIZE  to shared ALU
- alu_out  in  SIZE  from ALU
- alu_zero, alu_overflow  in  1  from ALU

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid, grant one requester. reqN_ready is asserted combinationally to the winner only.
  - On handshake, latch control/a/b/id, load cnt = MULT_CYCLES for control 6, else 1, and go to EXEC.
  - With no valid, remain in IDLE. Both readys are 0 outside IDLE.
- EXEC:
  - alu_control/alu_a/alu_b are driven from the latched registers. cnt decrements each cycle.
  - In the cycle with cnt==1, capture alu_out to resp_out and alu_zero to resp_zero.
  - resp_overflow = alu_overflow if control is 3 or 4, else 0.
  - Set resp_valid and go to RESP.
- RESP:
  - resp_* are held stable while resp_valid && !resp_ready.
  - On resp_valid && resp_ready, clear resp_valid and go to IDLE. A new grant is earliest the next cycle.
- Outside EXEC, alu_control = 4'b0000 and alu_a = alu_b = 0. This keeps the ALU quiescent and its output 0.
- Unlisted control codes (0, 8..15) are accepted and executed as 1-cycle ops. The result is resp_out = 0, resp_zero = 1, resp_overflow = 0.
- MULT returns the low SIZE bits only. The high half is discarded.
- Requesters hold valid and payload stable until ready. A requester must not drop valid before it is granted.
- Reset values: FSM IDLE, resp_valid 0, resp_id 0, resp_out 0, resp_zero 0, resp_overflow 0, alu_* 0, req*_ready 0, cnt 0, arbitration pointer favours port 0.
- Reset mid-operation: the in-flight op and any pending response are discarded with no output. The next cycle after rst_n is released is IDLE.

## Timing
- Handshake in cycle N:
  - EXEC begins in cycle N+1.
  - 1-cycle ops: resp_valid is first high in cycle N+2.
  - MULT: resp_valid is first high in cycle N+1+MULT_CYCLES.
- Minimum issue interval for back-to-back 1-cycle ops with resp_ready tied high is 3 cycles: accept at N, response at N+2, next accept at N+3.
- req*_ready depends combinationally on req*_valid and state. No other input-to-output combinational paths exist except alu_out → none (results are captured in registers).
- Simultaneous requests in IDLE: the arbiter picks one; the loser's valid persists and is served next.

## Configuration
- ALU_SHARE_RR_EN defined: round-robin arbitration.
  - After a grant to port k, the next simultaneous contest goes to port 1-k.
  - The pointer updates only on handshake and resets to favour port 0.
- Not defined: fixed priority, where port 0 always wins. Port 1 is granted only when req0_valid = 0.

## Test plan
- Single ADD: req0 control 3, a=5, b=7, handshake at N → resp_valid at N+2, resp_out 12, resp_id 0, resp_zero 0, resp_overflow 0.
- SUB borrow: req1 control 4, a=0, b=1 → resp_out 64'hFFFF_FFFF_FFFF_FFFF, resp_overflow 1, resp_id 1. Follow with AND a=b=0 → resp_zero 1, resp_overflow 0.
- MULT latency: MULT_CYCLES=4, a=3, b=64'h8000_0000_0000_0001, accept at N.
  - resp_valid first high at N+5, resp_out 64'h8000_0000_0000_0003.
  - alu_control = 6 for exactly cycles N+1..N+4.
- Contention: both valid continuously, each with 3 ops.
  - With ALU_SHARE_RR_EN, grants go 0,1,0,1,0,1.
  - Without it, grants go 0,0,0,1,1,1.
- Backpressure: resp_ready = 0 for 5 cycles after resp_valid.
  - resp_* stay stable and both readys stay 0.
  - When resp_ready = 1, the result is taken and the next grant occurs the following cycle.
- Reset mid-MULT: rst_n = 0 in cycle N+2 of a MULT → no response is ever issued. After release, all outputs are 0 and a new req0 EQ with a=b=9 returns resp_out 1.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Two-port sequencer/arbiter in front of the shared 64-bit execute-stage ALU.
// Define ALU_SHARE_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module alu_share_ctrl #(
    parameter int unsigned SIZE        = 64,
    parameter int unsigned MULT_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_control,
    input  logic [SIZE-1:0] req0_a,
    input  logic [SIZE-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_control,
    input  logic [SIZE-1:0] req1_a,
    input  logic [SIZE-1:0] req1_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [SIZE-1:0] resp_out,
    output logic            resp_zero,
    output logic            resp_overflow,
    output logic [3:0]      alu_control,
    output logic [SIZE-1:0] alu_a,
    output logic [SIZE-1:0] alu_b,
    input  logic [SIZE-1:0] alu_out,
    input  logic            alu_zero,
    input  logic            alu_overflow
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            cur_id;
    logic            grant0, grant1;
    logic [3:0]      sel_control;
    logic [SIZE-1:0] sel_a, sel_b;
    logic            known_op, addsub_op;

`ifdef ALU_SHARE_RR_EN
    logic            prio;  // 1: port 1 wins the next simultaneous contest

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = !prio;
            grant1 = prio;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end
`else
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`endif

    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;

    always_comb begin
        sel_control = req1_ready ? req1_control : req0_control;
        sel_a       = req1_ready ? req1_a : req0_a;
        sel_b       = req1_ready ? req1_b : req0_b;
    end

    // alu_control holds the latched op for the whole of EXEC
    assign known_op  = (alu_control != 4'd0) && (alu_control <= 4'd7);
    assign addsub_op = (alu_control == 4'd3) || (alu_control == 4'd4);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            cur_id        <= 1'b0;
            alu_control   <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            resp_valid    <= 1'b0;
            resp_id       <= 1'b0;
            resp_out      <= '0;
            resp_zero     <= 1'b0;
            resp_overflow <= 1'b0;
`ifdef ALU_SHARE_RR_EN
            prio          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        cur_id      <= req1_ready;
                        alu_control <= sel_control;
                        alu_a       <= sel_a;
                        alu_b       <= sel_b;
                        cnt         <= (sel_control == 4'd6) ? 4'(MULT_CYCLES) : 4'd1;
                        state       <= EXEC;
`ifdef ALU_SHARE_RR_EN
                        prio        <= req0_ready;
`endif
                    end
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        resp_out      <= known_op ? alu_out : '0;
                        resp_zero     <= known_op ? alu_zero : 1'b1;
                        resp_overflow <= addsub_op && alu_overflow;
                        resp_id       <= cur_id;
                        resp_valid    <= 1'b1;
                        alu_control   <= '0;
                        alu_a         <= '0;
                        alu_b         <= '0;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized bench for alu_share_ctrl with a noisy ALU stand-in and a
// transaction-level reference (latency, arbitration, result). Honours ALU_SHARE_RR_EN.
module tb_alu_share_ctrl;

    localparam int unsigned MC = 4;
`ifdef ALU_SHARE_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  c;
        logic [63:0] a;
        logic [63:0] b;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_control = '0, req1_control = '0;
    logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        resp_valid, resp_id, resp_zero, resp_overflow;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_out;
    logic [3:0]  alu_control;
    logic [63:0] alu_a, alu_b, alu_out;
    logic        alu_zero, alu_overflow;
    logic [65:0] stub_r;

    always #5 clk = ~clk;

    alu_share_ctrl #(.SIZE(64), .MULT_CYCLES(MC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_control(req0_control),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_control(req1_control),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_out(resp_out), .resp_zero(resp_zero), .resp_overflow(resp_overflow),
        .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow)
    );

    // Expected response {overflow, zero, out} from the op definitions
    function automatic logic [65:0] ref_result(input logic [3:0] c, input logic [63:0] a,
                                               input logic [63:0] b);
        logic [64:0] w;
        logic [63:0] r;
        logic        ov;
        ov = 1'b0;
        w  = '0;
        case (c)
            4'd1: r = a & b;
            4'd2: r = a | b;
            4'd3: begin w = {1'b0, a} + {1'b0, b}; r = w[63:0]; ov = w[64]; end
            4'd4: begin r = a - b; ov = (a < b); end
            4'd5: r = (a == b) ? 64'd1 : 64'd0;
            4'd6: r = a * b;
            4'd7: r = ~(a | b);
            default: r = '0;
        endcase
        return {ov, (r == 64'd0), r};
    endfunction

    // ALU stand-in: overflow asserted on non-ADD/SUB ops and junk output on unlisted codes
    always_comb begin
        stub_r       = ref_result(alu_control, alu_a, alu_b);
        alu_out      = stub_r[63:0];
        alu_zero     = stub_r[64];
        alu_overflow = stub_r[65];
        if (alu_control != 4'd3 && alu_control != 4'd4) alu_overflow = 1'b1;
        if (alu_control == 4'd0 || alu_control > 4'd7) begin
            alu_out  = alu_a ^ ~alu_b;
            alu_zero = 1'b0;
        end
    end

    int          total = 0, bad = 0, cyc = 0;
    op_t         q0[$], q1[$];
    bit          busy = 0, ptr = 0, hs0 = 0, hs1 = 0;
    bit          bp_phase = 0, bp_rhs_seen = 0;
    op_t         m_op;
    bit          m_id;
    int          hs_cyc = 0, due = 0, last_rhs = 0;
    int          rr_mode = 1, rv_cnt = 0, mult_seen = 0;
    int          grant_log[$];
    logic [63:0] last_out = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic drive();
        op_t z;
        z = '0;
        req0_valid = (q0.size() != 0);
        req1_valid = (q1.size() != 0);
        {req0_control, req0_a, req0_b} = req0_valid ? q0[0] : z;
        {req1_control, req1_a, req1_b} = req1_valid ? q1[0] : z;
        case (rr_mode)
            0:       resp_ready = ($urandom_range(0, 3) != 0);
            1:       resp_ready = 1'b1;
            default: resp_ready = (rv_cnt >= 5);
        endcase
    endtask

    task automatic push(input int port, input logic [3:0] c, input logic [63:0] a,
                        input logic [63:0] b);
        op_t o;
        o = '{c: c, a: a, b: b};
        if (port == 0) q0.push_back(o); else q1.push_back(o);
        drive();
    endtask

    task automatic sample_cycle();
        bit          erv, exe, any;
        int          win;
        logic [65:0] e;
        e   = ref_result(m_op.c, m_op.a, m_op.b);
        erv = busy && (cyc >= due);
        chk("resp_valid", resp_valid, erv);
        if (erv) begin
            chk("resp_out", resp_out, e[63:0]);
            chk("resp_zero", resp_zero, e[64]);
            chk("resp_overflow", resp_overflow, e[65]);
            chk("resp_id", resp_id, m_id);
        end
        exe = busy && (cyc > hs_cyc) && (cyc < due);
        chk("alu_control", alu_control, exe ? m_op.c : 4'd0);
        chk("alu_a", alu_a, exe ? m_op.a : 64'd0);
        chk("alu_b", alu_b, exe ? m_op.b : 64'd0);
        if (alu_control == 4'd6) mult_seen++;

        any = !busy && (req0_valid || req1_valid);
        win = 0;
        if (req0_valid && req1_valid) win = RR_EN ? int'(ptr) : 0;
        else win = req1_valid ? 1 : 0;
        chk("req0_ready", req0_ready, any && win == 0);
        chk("req1_ready", req1_ready, any && win == 1);

        rv_cnt = resp_valid ? rv_cnt + 1 : 0;
        if (erv && resp_ready) begin
            busy     = 0;
            last_rhs = cyc;
            last_out = e[63:0];
            if (bp_phase) bp_rhs_seen = 1;
        end
        if (any) begin
            if (bp_rhs_seen) begin
                chk("grant_after_resp", cyc - last_rhs, 1);
                bp_rhs_seen = 0;
            end
            hs0    = (win == 0);
            hs1    = (win == 1);
            m_op   = (win == 0) ? q0[0] : q1[0];
            m_id   = (win == 1);
            busy   = 1;
            hs_cyc = cyc;
            due    = cyc + ((m_op.c == 4'd6) ? int'(MC) + 1 : 2);
            ptr    = (win == 0);
            grant_log.push_back(win);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        hs0 = 0;
        hs1 = 0;
        if (rst_n) sample_cycle();
        else chk("resp_valid_in_reset", resp_valid, 1'b0);
        @(posedge clk);
        #1;
        if (hs0) q0.delete(0);
        if (hs1) q1.delete(0);
        drive();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((busy || q0.size() != 0 || q1.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain", {63'd0, busy || q0.size() != 0 || q1.size() != 0}, 64'd0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        drive();
        repeat (n) cycle();
        rst_n  = 1'b1;
        busy   = 0;
        ptr    = 0;
        rv_cnt = 0;
        cycle();
        chk("rst_resp_out", resp_out, 64'd0);
        chk("rst_resp_id", resp_id, 1'b0);
        chk("rst_resp_zero", resp_zero, 1'b0);
        chk("rst_resp_overflow", resp_overflow, 1'b0);
    endtask

    initial begin
        int exp_seq[6];
        int n;
        do_reset(3);

        push(0, 4'd3, 64'd5, 64'd7);
        run_until_idle(20);
        chk("add_out", last_out, 64'd12);

        push(1, 4'd4, 64'd0, 64'd1);
        run_until_idle(20);
        chk("sub_out", last_out, 64'hFFFF_FFFF_FFFF_FFFF);
        push(1, 4'd1, 64'd0, 64'd0);
        run_until_idle(20);
        chk("and_out", last_out, 64'd0);

        mult_seen = 0;
        push(0, 4'd6, 64'd3, 64'h8000_0000_0000_0001);
        run_until_idle(20);
        chk("mult_out", last_out, 64'h8000_0000_0000_0003);
        chk("mult_cycles", mult_seen, MC);

        do_reset(2);
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            push(0, 4'($urandom_range(1, 7)), {$urandom, $urandom}, {$urandom, $urandom});
            push(1, 4'($urandom_range(1, 7)), {$urandom, $urandom}, {$urandom, $urandom});
        end
        run_until_idle(100);
        exp_seq = RR_EN ? '{0, 1, 0, 1, 0, 1} : '{0, 0, 0, 1, 1, 1};
        chk("grant_count", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk($sformatf("grant[%0d]", i), grant_log[i], exp_seq[i]);

        rr_mode  = 2;
        bp_phase = 1;
        push(0, 4'd2, 64'hF0, 64'h0F);
        push(0, 4'd7, 64'd0, 64'd0);
        push(1, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        run_until_idle(100);
        bp_phase = 0;
        rr_mode  = 1;

        push(0, 4'd6, 64'd7, 64'd9);
        n = 0;
        while (!busy && n < 10) begin cycle(); n++; end
        chk("mult_accepted", busy, 1'b1);
        cycle();
        do_reset(2);
        repeat (8) cycle();
        push(0, 4'd5, 64'd9, 64'd9);
        run_until_idle(20);
        chk("eq_out", last_out, 64'd1);

        rr_mode = 0;
        for (int batch = 0; batch < 4; batch++) begin
            for (int i = 0; i < 10; i++) begin
                logic [63:0] a, b;
                a = {$urandom, $urandom};
                b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) b = ~a;
                push($urandom_range(0, 1), 4'($urandom_range(0, 15)), a, b);
            end
            run_until_idle(600);
            repeat ($urandom_range(0, 3)) cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
